hex_scan_driver: RTL and testbench

Downstream consumer of the 16-bit hex number produced by the number-generator stage. Time-multiplexes the four nibbles onto a common-anode 4-digit seven-segment display. Outputs are active-low anode selects and segment drives. The input number is captured into a shadow register once per frame, so a digit update from upstream never tears a frame mid-scan.

---
 rtl/hex_scan_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_hex_scan_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexes a 16-bit hex value onto a common-anode
// 4-digit seven-segment display. Anodes and segments are active-low. The value
// is captured into a shadow register once per frame so upstream updates never
// tear a frame.
// Optional build macro: HEX_SCAN_LEADING_ZERO_BLANK_EN darkens leading zero
// digits 1..3 unless their decimal point is requested.
`timescale 1ns/1ps
module hex_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] num,
  input  logic [3:0]  points,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_sel_q, digit_sel_d;
  logic [15:0]      shadow_num_q, shadow_num_d;
  logic [3:0]       shadow_pts_q, shadow_pts_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_tick_q, frame_tick_d;

  logic             tick_s;
  logic             load_s;
  logic             advance_s;
  logic             blank_s;
  logic [1:0]       next_sel_s;
  logic [3:0]       next_nib_s;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Nibble i of a 16-bit value.
  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Active-low one-hot anode pattern for digit i.
  function automatic logic [3:0] anode_of(input logic [1:0] i);
    logic [3:0] a;
    case (i)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      2'd3:    a = 4'b0111;
      default: a = 4'b1111;
    endcase
    return a;
  endfunction

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  // True when digit i is a leading zero with no decimal point requested.
  function automatic logic is_leading_zero(input logic [15:0] v, input logic [3:0] p,
                                           input logic [1:0] i);
    logic z;
    case (i)
      2'd1:    z = (v[15:4]  == 12'h000) && !p[1];
      2'd2:    z = (v[15:8]  == 8'h00)   && !p[2];
      2'd3:    z = (v[15:12] == 4'h0)    && !p[3];
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  assign tick_s     = (div_cnt_q == DIV_LAST);
  assign next_sel_s = digit_sel_q + 2'd1;
  assign next_nib_s = nibble_of(shadow_num_q, next_sel_s);

  // Next-state logic: FSM transitions, divider, frame load and digit advance.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    digit_sel_d  = digit_sel_q;
    shadow_num_d = shadow_num_q;
    shadow_pts_d = shadow_pts_q;
    an_d         = an_q;
    seg_d        = seg_q;
    frame_tick_d = 1'b0;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    blank_s      = 1'b0;

    case (state_q)
      IDLE: begin
        // The divider only runs toward the first tick while enabled; it holds otherwise.
        if (en) begin
          div_cnt_d = tick_s ? '0 : div_cnt_q + DIV_ONE;
        end else begin
          div_cnt_d = div_cnt_q;
        end
        if (en && tick_s) begin
          state_d = SCAN;
          load_s  = 1'b1;
        end else begin
          blank_s = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          blank_s   = 1'b1;
        end else begin
          div_cnt_d = tick_s ? '0 : div_cnt_q + DIV_ONE;
          if (tick_s && (digit_sel_q == 2'd3)) begin
            load_s = 1'b1;
          end else if (tick_s) begin
            advance_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
        blank_s   = 1'b1;
      end
    endcase

    if (load_s) begin
      // Digit 0 is shown from the freshly sampled inputs, not the old shadow.
      shadow_num_d = num;
      shadow_pts_d = points;
      digit_sel_d  = 2'd0;
      frame_tick_d = 1'b1;
      an_d         = 4'b1110;
      seg_d        = {~points[0], hex_decode(num[3:0])};
    end else if (advance_s) begin
      digit_sel_d = next_sel_s;
      seg_d       = {~shadow_pts_q[next_sel_s], hex_decode(next_nib_s)};
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      if (is_leading_zero(shadow_num_q, shadow_pts_q, next_sel_s)) begin
        an_d = 4'b1111;
      end else begin
        an_d = anode_of(next_sel_s);
      end
`else
      an_d = anode_of(next_sel_s);
`endif
    end else if (blank_s) begin
      digit_sel_d = 2'd0;
      an_d        = 4'b1111;
      seg_d       = 8'hFF;
    end else begin
      digit_sel_d = digit_sel_q;
    end
  end

  // State and output registers with asynchronous blanking reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      digit_sel_q  <= 2'd0;
      shadow_num_q <= 16'h0000;
      shadow_pts_q <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      digit_sel_q  <= digit_sel_d;
      shadow_num_q <= shadow_num_d;
      shadow_pts_q <= shadow_pts_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (SCAN_DIV=4): constant vector table,
// hand-written corner sequences and randomized stimulus against a reference model.
`timescale 1ns/1ps
module tb_hex_scan_driver;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] num;
  logic [3:0]  points;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  hex_scan_driver #(.SCAN_DIV(SCAN_DIV), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .num(num), .points(points),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_scanning;
  int          m_cnt;
  int          m_dig;
  logic [15:0] m_sh;
  logic [3:0]  m_pts;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;
  logic        m_ft;

  function automatic void model_reset();
    m_scanning = 1'b0; m_cnt = 0; m_dig = 0;
    m_sh = 16'h0000; m_pts = 4'h0;
    m_an = 4'hF; m_seg = 8'hFF; m_ft = 1'b0;
  endfunction

  function automatic void show_digit(input logic [15:0] v, input logic [3:0] p, input int d);
    m_seg = {~p[d], seg_tab[(v >> (4 * d)) & 16'hF]};
    m_an  = 4'hF ^ (4'h1 << d);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0 && !p[d]) m_an = 4'hF;
`endif
  endfunction

  // One rising edge worth of behaviour, from the externally visible rules.
  function automatic void model_step(input logic e, input logic [15:0] n, input logic [3:0] p);
    bit tick;
    m_ft = 1'b0;
    if (m_scanning && !e) begin
      m_scanning = 1'b0; m_cnt = 0; m_dig = 0; m_an = 4'hF; m_seg = 8'hFF;
    end else if (e) begin
      tick  = (m_cnt == SCAN_DIV - 1);
      m_cnt = (m_cnt + 1) % SCAN_DIV;
      if (tick) begin
        if (!m_scanning || m_dig == 3) begin
          m_sh = n; m_pts = p; m_dig = 0; m_ft = 1'b1;
          show_digit(n, p, 0);
        end else begin
          m_dig = m_dig + 1;
          show_digit(m_sh, m_pts, m_dig);
        end
        m_scanning = 1'b1;
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step(en, num, points);
    #1;
    check("model_an", {28'h0, an}, {28'h0, m_an});
    check("model_seg", {24'h0, seg}, {24'h0, m_seg});
    check("model_ft", {31'h0, frame_tick}, {31'h0, m_ft});
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    for (int i = 1; i <= 8 * SCAN_DIV + 8; i++) begin
      run_cycle();
      if (frame_tick) begin
        n = i;
        break;
      end
    end
    n_checks++;
    if (n == 0) begin
      n_errors++;
      $display("FAIL frame_wait: no frame_tick within %0d cycles", 8 * SCAN_DIV + 8);
    end
  endtask

  typedef struct packed {
    logic [15:0]     num;
    logic [3:0]      pts;
    logic [3:0][7:0] seg;   // expected seg for digit 3..0
    logic [3:0][3:0] an;    // expected an for digit 3..0
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n;
    int ticks;

    // Frame table: expected seg/an per digit slot, derived by hand from the decode table.
    tbl[0] = '{16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tbl[1] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}};
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    tbl[2] = '{16'h0000, 4'b0101, {8'hC0, 8'h40, 8'hC0, 8'h40}, {4'hF, 4'hB, 4'hF, 4'hE}};
    tbl[3] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE}};
`else
    tbl[2] = '{16'h0000, 4'b0101, {8'hC0, 8'h40, 8'hC0, 8'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tbl[3] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
`endif
    tbl[4] = '{16'h89EF, 4'b1010, {8'h00, 8'h90, 8'h06, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tbl[5] = '{16'h5670, 4'b1111, {8'h12, 8'h02, 8'h78, 8'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};

    // Reset state.
    rst_n = 1'b0; en = 1'b0; num = 16'h0000; points = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_an", {28'h0, an}, 32'hF);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    check("reset_ft", {31'h0, frame_tick}, 32'h0);

    // First tick latency after release with en=1.
    rst_n = 1'b1; en = 1'b1; num = 16'hABCD; points = 4'h0;
    wait_frame(n);
    check("first_tick_latency", n, SCAN_DIV);
    check("first_an", {28'h0, an}, 32'hE);
    check("first_seg", {24'h0, seg}, 32'hA1);

    // Table of full frames.
    for (int r = 0; r < 6; r++) begin
      num = tbl[r].num; points = tbl[r].pts;
      wait_frame(n);
      for (int d = 0; d < 4; d++) begin
        if (d > 0) repeat (SCAN_DIV) run_cycle();
        check("tbl_an", {28'h0, an}, {28'h0, tbl[r].an[d]});
        check("tbl_seg", {24'h0, seg}, {24'h0, tbl[r].seg[d]});
      end
    end

    // num change during digit 2's slot does not affect the current frame.
    num = 16'hABCD; points = 4'h0;
    wait_frame(n);
    repeat (2 * SCAN_DIV + 1) run_cycle();
    num = 16'h1234;
    repeat (SCAN_DIV - 1) run_cycle();
    check("midframe_d3_an", {28'h0, an}, 32'h7);
    check("midframe_d3_seg", {24'h0, seg}, 32'h88);
    wait_frame(n);
    check("newframe_seg", {24'h0, seg}, 32'h99);

    // Exactly one frame_tick per 4*SCAN_DIV cycles.
    ticks = 0;
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      run_cycle();
      if (frame_tick) ticks++;
    end
    check("frame_tick_rate", ticks, 4);

    // en drop mid-frame blanks on the next edge and holds.
    repeat (SCAN_DIV + 1) run_cycle();
    en = 1'b0;
    run_cycle();
    check("endrop_an", {28'h0, an}, 32'hF);
    check("endrop_seg", {24'h0, seg}, 32'hFF);
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("idle_hold_an", {28'h0, an}, 32'hF);
    end
    en = 1'b1;
    wait_frame(n);
    check("reenable_latency", n, SCAN_DIV);
    check("reenable_an", {28'h0, an}, 32'hE);

    // en rising mid-count in IDLE: the divider holds while en is low.
    en = 1'b0;
    run_cycle();
    en = 1'b1;
    repeat (2) run_cycle();
    en = 1'b0;
    repeat (3) run_cycle();
    en = 1'b1;
    wait_frame(n);
    check("midcount_latency", n, SCAN_DIV - 2);

    // Asynchronous reset between edges during SCAN.
    repeat (SCAN_DIV + 1) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an", {28'h0, an}, 32'hF);
    check("async_rst_seg", {24'h0, seg}, 32'hFF);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    num = 16'h0000; points = 4'h0;
    rst_n = 1'b1;
    wait_frame(n);
    check("post_rst_latency", n, SCAN_DIV);
    check("post_rst_seg", {24'h0, seg}, 32'hC0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      run_cycle();
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) begin
        num = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom) & 16'h00FF);
      end
      if ($urandom_range(0, 15) == 0) points = 4'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
